// File: rtl/msb_scan_pkg.sv
// Shared types and sizing helpers for the sequential leading/trailing-one finder.
// Optional feature macro used by the top: MSB_SCAN_EARLY_ZERO_EN.
package msb_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CHUNK = 8;

  localparam string WIDTH_CHUNK_MSG =
    "msb_scan_seq: WIDTH must be a non-zero multiple of CHUNK";

  function automatic int msbNchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int msbPosW(input int width);
    return $clog2(width + 1);
  endfunction

  // Slice index width; a single-slice build still needs a one-bit register.
  function automatic int msbIdxW(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage : msb_scan_pkg

// File: rtl/msb_chunk_enc.sv
// Combinational CHUNK-bit encoder: 1-based position of the highest (or lowest)
// set bit in one slice, plus a nonzero flag.
module msb_chunk_enc
  import msb_scan_pkg::*;
#(
  parameter int CHUNK = DEFAULT_CHUNK,
  parameter int LP_W  = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] slice_i,
  input  logic             lsb_mode_i,
  output logic [LP_W-1:0]  local_pos_o,
  output logic             nonzero_o
);

  // The last hit in each loop wins: ascending scan keeps the highest bit,
  // descending scan keeps the lowest.
  always_comb begin
    local_pos_o = '0;
    if (lsb_mode_i) begin
      for (int i = CHUNK - 1; i >= 0; i--) begin
        if (slice_i[i]) local_pos_o = LP_W'(i + 1);
      end
    end else begin
      for (int i = 0; i < CHUNK; i++) begin
        if (slice_i[i]) local_pos_o = LP_W'(i + 1);
      end
    end
  end

  assign nonzero_o = |slice_i;

endmodule : msb_chunk_enc

// File: rtl/msb_scan_seq.sv
// Sequential leading-one / trailing-one finder, one CHUNK slice per clock,
// with valid/ready on both sides. Optional macro: MSB_SCAN_EARLY_ZERO_EN.
module msb_scan_seq
  import msb_scan_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int CHUNK  = DEFAULT_CHUNK,
  parameter int NCHUNK = msbNchunk(WIDTH, CHUNK),
  parameter int POS_W  = msbPosW(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_lsb_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [POS_W-1:0] out_pos,
  output logic             out_zero
);

  localparam int IDX_W = msbIdxW(NCHUNK);
  localparam int LP_W  = $clog2(CHUNK + 1);

  localparam logic [IDX_W-1:0] IDX_FIRST_MSB = IDX_W'(NCHUNK - 1);
  localparam logic [IDX_W-1:0] IDX_FIRST_LSB = '0;

  if ((CHUNK <= 0) || (WIDTH % CHUNK != 0)) begin : gWidthCheck
    $error("%s", WIDTH_CHUNK_MSG);
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             lsb_q, lsb_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             zero_q, zero_d;

  logic [CHUNK-1:0] sliceW;
  logic [LP_W-1:0]  localPos;
  logic             sliceNonzero;
  logic             lastSlice;

  assign sliceW = data_q[idx_q * CHUNK +: CHUNK];

  msb_chunk_enc #(
    .CHUNK (CHUNK),
    .LP_W  (LP_W)
  ) uChunkEnc (
    .slice_i     (sliceW),
    .lsb_mode_i  (lsb_q),
    .local_pos_o (localPos),
    .nonzero_o   (sliceNonzero)
  );

  assign lastSlice = lsb_q ? (idx_q == IDX_FIRST_MSB) : (idx_q == IDX_FIRST_LSB);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      lsb_q   <= 1'b0;
      idx_q   <= '0;
      pos_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      lsb_q   <= lsb_d;
      idx_q   <= idx_d;
      pos_q   <= pos_d;
      zero_q  <= zero_d;
    end
  end

  // DONE holds the result registers untouched until the consumer takes them.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    lsb_d   = lsb_q;
    idx_d   = idx_q;
    pos_d   = pos_q;
    zero_d  = zero_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          lsb_d   = in_lsb_mode;
          idx_d   = in_lsb_mode ? IDX_FIRST_LSB : IDX_FIRST_MSB;
          state_d = SCAN;
`ifdef MSB_SCAN_EARLY_ZERO_EN
          if (in_data == '0) begin
            pos_d   = '0;
            zero_d  = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end

      SCAN: begin
        if (sliceNonzero) begin
          pos_d   = POS_W'(idx_q) * POS_W'(CHUNK) + POS_W'(localPos);
          zero_d  = 1'b0;
          state_d = DONE;
        end else if (lastSlice) begin
          pos_d   = '0;
          zero_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = lsb_q ? (idx_q + IDX_W'(1)) : (idx_q - IDX_W'(1));
        end
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_pos   = pos_q;
  assign out_zero  = zero_q;

endmodule : msb_scan_seq

// File: tb/tb_msb_scan_seq.sv
// Self-checking bench for msb_scan_seq: scoreboard of expected position, zero
// flag and latency, backpressure and mid-scan reset scenarios.
module tb_msb_scan_seq;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int POS_W  = $clog2(WIDTH + 1);

  typedef struct {
    int unsigned pos;
    int unsigned zero;
    int unsigned lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_lsb_mode;
  logic             out_valid;
  logic             out_ready;
  logic [POS_W-1:0] out_pos;
  logic             out_zero;

  exp_t sbQ[$];
  int   compared   = 0;
  int   mismatched = 0;

  msb_scan_seq #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_lsb_mode (in_lsb_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pos     (out_pos),
    .out_zero    (out_zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int unsigned actual,
                             input int unsigned expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int unsigned modelPos(input logic [WIDTH-1:0] d, input logic lsb);
    int unsigned p;
    p = 0;
    if (lsb) begin
      for (int i = 0; i < WIDTH; i++) if (d[i] && p == 0) p = i + 1;
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) if (d[i] && p == 0) p = i + 1;
    end
    return p;
  endfunction

  function automatic int unsigned modelLat(input int unsigned pos, input logic lsb);
    if (pos == 0) begin
`ifdef MSB_SCAN_EARLY_ZERO_EN
      return 0;
`else
      return NCHUNK;
`endif
    end
    if (lsb) return (pos - 1) / CHUNK + 1;
    return NCHUNK - (pos - 1) / CHUNK;
  endfunction

  // One full transaction: offer, accept, wait result, optional backpressure, release.
  task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic lsb,
                               input int holdCycles);
    exp_t e, got;
    int   guard;
    int   edges;
    logic [POS_W-1:0] heldPos;
    logic             heldZero;

    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("inReadyBeforeOffer", in_ready, 1);

    in_data     = d;
    in_lsb_mode = lsb;
    in_valid    = 1'b1;
    e.pos  = modelPos(d, lsb);
    e.zero = (d == '0) ? 1 : 0;
    e.lat  = modelLat(e.pos, lsb);
    sbQ.push_back(e);

    @(posedge clk);
    @(negedge clk);
    in_valid    = 1'b0;
    in_data     = ~d;
    in_lsb_mode = ~lsb;
    edges = 0;
    while (!out_valid && edges < 3 * NCHUNK) begin
      @(negedge clk);
      edges++;
    end
    checkOutput("outValidSeen", out_valid, 1);

    if (sbQ.size() == 0) begin
      checkOutput("scoreboardEmpty", 0, 1);
    end else begin
      got = sbQ.pop_front();
      checkOutput("outPos", out_pos, got.pos);
      checkOutput("outZero", out_zero, got.zero);
      checkOutput("latency", edges, got.lat);
    end

    heldPos  = out_pos;
    heldZero = out_zero;
    for (int i = 0; i < holdCycles; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      @(negedge clk);
      checkOutput("holdValid", out_valid, 1);
      checkOutput("holdPos", out_pos, heldPos);
      checkOutput("holdZero", out_zero, heldZero);
      checkOutput("holdInReady", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("releaseValidLow", out_valid, 0);
    checkOutput("releaseInReady", in_ready, 1);
  endtask

  initial begin
    int guard;
    int validSeen;

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_lsb_mode = 1'b0;
    out_ready   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetOutValid", out_valid, 0);
    checkOutput("resetOutPos", out_pos, 0);
    checkOutput("resetOutZero", out_zero, 0);
    checkOutput("resetInReady", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(32'h8000_0000, 1'b0, 0);
    applyStimulus(32'h0000_0001, 1'b0, 0);
    applyStimulus(32'h0000_0000, 1'b0, 0);
    applyStimulus(32'h0000_0000, 1'b1, 0);
    applyStimulus(32'h0001_0100, 1'b1, 0);
    applyStimulus(32'h0001_0100, 1'b0, 5);
    applyStimulus(32'h0000_0001, 1'b1, 0);
    applyStimulus(32'h8000_0000, 1'b1, 2);
    applyStimulus(32'hFFFF_FFFF, 1'b0, 0);
    applyStimulus(32'hFFFF_FFFF, 1'b1, 0);
    applyStimulus(32'h0080_0000, 1'b0, 0);
    applyStimulus(32'h0000_8000, 1'b1, 1);
    for (int i = 0; i < 8; i++) begin
      logic [WIDTH-1:0] r;
      r = $urandom >> $urandom_range(0, 31);
      applyStimulus(r, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    // Reset while scanning: the pending result must vanish.
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    in_data     = 32'h0000_0001;
    in_lsb_mode = 1'b0;
    in_valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("midScanBusy", in_ready, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midRstOutValid", out_valid, 0);
    checkOutput("midRstOutPos", out_pos, 0);
    checkOutput("midRstOutZero", out_zero, 0);
    checkOutput("midRstInReady", in_ready, 1);
    validSeen = 0;
    for (int i = 0; i < 2 * NCHUNK; i++) begin
      @(negedge clk);
      if (out_valid) validSeen++;
    end
    checkOutput("midRstNoResult", validSeen, 0);

    applyStimulus(32'h0000_0100, 1'b0, 0);
    checkOutput("scoreboardDrained", sbQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule : tb_msb_scan_seq
